dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit words in the shared data memory.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one port while the other port is requesting.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_a, req_b  input  1  access request from port A (CPU) and port B (DMA).
REQ-006 SHALL have ports we_a, we_b  input  1  1=write, 0=read; valid while req_x=1.
REQ-007 SHALL have ports addr_a, addr_b  input  32  word address; valid while req_x=1.
REQ-008 SHALL have ports wdata_a, wdata_b  input  32  write data; valid while req_x=1.
REQ-009 SHALL have ports gnt_a, gnt_b  output  1  transfer accepted this cycle.
REQ-010 SHALL have ports rvalid_a, rvalid_b  output  1  read data valid, one-cycle pulse.
REQ-011 SHALL have ports rdata_a, rdata_b  output  32  read data, meaningful only while rvalid_x=1.
REQ-012 SHALL have ports err_a, err_b  output  1  out-of-range access response, one-cycle pulse.
REQ-013 SHALL have port mem_addr  output  32  memory address.
REQ-014 SHALL have port mem_wdata  output  32  memory write data.
REQ-015 SHALL have ports mem_write, mem_read  output  1  memory write and read strobes.
REQ-016 SHALL have port mem_rdata  input  32  combinational memory read data.

Function
REQ-017 SHALL implement an FSM with states IDLE, OWN_A and OWN_B, plus a last_served flag and a burst counter.
REQ-018 SHALL complete a transfer on port x in any cycle where req_x=1 and gnt_x=1; the requester holds req_x, we_x, addr_x and wdata_x stable until that cycle.
REQ-019 SHALL generate gnt_x combinationally from the current state and the req inputs, at most one grant per cycle, with gnt_x=0 whenever req_x=0.
REQ-020 In IDLE, SHALL grant the only requester, or on a tie grant the port opposite to last_served.
REQ-021 In OWN_x, SHALL grant x if req_x=1 and (the other port is idle or burst_cnt<MAX_BURST), else grant the other port if it is requesting.
REQ-022 On each grant, SHALL move to OWN_<granted> and update last_served; burst_cnt becomes 1 on an owner change and increments (saturating at MAX_BURST) on a repeat grant.
REQ-023 SHALL return to IDLE with burst_cnt=0 on any cycle with no grant.
REQ-024 SHALL route the granted port's addr/wdata to mem_addr/mem_wdata and assert mem_write=we or mem_read=!we in the grant cycle only; all mem_* outputs are 0 when there is no grant.
REQ-025 SHALL register mem_rdata on a granted read and pulse rvalid_x with that data one cycle later (latency 1); back-to-back reads give back-to-back rvalid pulses.
REQ-026 SHALL treat a write as complete at its grant, with no rvalid pulse.
REQ-027 For addr>=MEM_DEPTH, SHALL still grant but suppress mem_read/mem_write, then pulse err_x one cycle later with rdata_x=0 and no rvalid.
REQ-028 SHALL drive rdata_x=0 whenever rvalid_x=0.

Reset
REQ-029 While reset=1, SHALL hold gnt_*, rvalid_*, err_*, rdata_*, mem_* at 0, state=IDLE, burst_cnt=0, last_served=B (A wins the first tie).
REQ-030 SHALL discard a pending read response when reset is asserted mid-transfer; no rvalid pulse after release.

Structure
REQ-031 SHALL place the state encoding (IDLE/OWN_A/OWN_B) and port-ID constants (PORT_A=0, PORT_B=1) in shared package dmem_pkg.
REQ-032 SHALL contain one sub-module, rr_pick, for the combinational round-robin/burst grant decision; the FSM, mux and response registers stay in dmem_arbiter.

Verification
REQ-033 Bench SHALL check: reset release, both req on cycle 1 -> gnt_a first, then alternating while both reads persist with MAX_BURST=1.
REQ-034 Bench SHALL check: A reads addr 5 (memory holds 0xDEADBEEF) -> mem_read=1 in grant cycle, rvalid_a=1 and rdata_a=0xDEADBEEF next cycle.
REQ-035 Bench SHALL check: A requests continuously, B asserts req at cycle 2, MAX_BURST=4 -> A receives at most 4 consecutive grants, then gnt_b.
REQ-036 Bench SHALL check: B writes 0x12345678 to addr 300 with MEM_DEPTH=256 -> gnt_b=1, mem_write=0, err_b pulses next cycle.
REQ-037 Bench SHALL check: reset asserted in the cycle after A's read grant -> rvalid_a stays 0 and all outputs are 0 after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-port data-memory arbiter.
package dmem_pkg;

   // Arbiter ownership states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_e;

   // Port identifiers, used for the last_served flag
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational grant decision: round-robin on ties from IDLE,
// burst-limited ownership while one port owns the memory.
module rr_pick
   import dmem_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 3
)
(
   input  arb_state_e       state_i,
   input  logic             req_a_i,
   input  logic             req_b_i,
   input  logic             last_served_i,
   input  logic [CNT_W-1:0] burst_cnt_i,
   output logic             gnt_a_o,
   output logic             gnt_b_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   // Pick at most one port; never grant a port that is not requesting
   always_comb begin
      gnt_a_o = 1'b0;
      gnt_b_o = 1'b0;
      case (state_i)
         OWN_A: begin
            if (req_a_i && (!req_b_i || (burst_cnt_i < MAX_CNT))) gnt_a_o = 1'b1;
            else if (req_b_i)                                     gnt_b_o = 1'b1;
         end
         OWN_B: begin
            if (req_b_i && (!req_a_i || (burst_cnt_i < MAX_CNT))) gnt_b_o = 1'b1;
            else if (req_a_i)                                     gnt_a_o = 1'b1;
         end
         default: begin
            // On a tie the port that was not served last wins
            if (req_a_i && req_b_i) begin
               if (last_served_i == PORT_B) gnt_a_o = 1'b1;
               else                         gnt_b_o = 1'b1;
            end else begin
               gnt_a_o = req_a_i;
               gnt_b_o = req_b_i;
            end
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory.
// A port completes a transfer in the cycle req_x && gnt_x; reads return
// one cycle later on rvalid_x, out-of-range accesses return err_x instead.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int MAX_BURST = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_a,
   input  logic        req_b,
   input  logic        we_a,
   input  logic        we_b,
   input  logic [31:0] addr_a,
   input  logic [31:0] addr_b,
   input  logic [31:0] wdata_a,
   input  logic [31:0] wdata_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        rvalid_a,
   output logic        rvalid_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b,
   output logic        err_a,
   output logic        err_b,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_rdata,
   output arb_state_e  dbg_state_o
);

   localparam int              CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [31:0]     DEPTH   = 32'(MEM_DEPTH);

   arb_state_e       state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] burst_q, burst_d;

   logic             rvalid_a_q, rvalid_b_q, err_a_q, err_b_q;
   logic [31:0]      rdata_q;

   logic             pick_a, pick_b;
   logic             gnt_a_int, gnt_b_int, gnt_any;
   logic             sel_we, in_range;
   logic [31:0]      sel_addr, sel_wdata;

   rr_pick #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_pick (
      .state_i       (state_q),
      .req_a_i       (req_a),
      .req_b_i       (req_b),
      .last_served_i (last_q),
      .burst_cnt_i   (burst_q),
      .gnt_a_o       (pick_a),
      .gnt_b_o       (pick_b)
   );

   // Grants are suppressed while reset is held; select the winning port's request
   always_comb begin
      gnt_a_int = pick_a & ~reset;
      gnt_b_int = pick_b & ~reset;
      gnt_any   = gnt_a_int | gnt_b_int;
      sel_we    = gnt_b_int ? we_b    : we_a;
      sel_addr  = gnt_b_int ? addr_b  : addr_a;
      sel_wdata = gnt_b_int ? wdata_b : wdata_a;
      in_range  = sel_addr < DEPTH;
   end

   // State register: ownership, last served port, burst length
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= PORT_B;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   // Next state: follow the grant; an empty cycle drops ownership
   always_comb begin
      state_d = IDLE;
      last_d  = last_q;
      burst_d = '0;
      if (gnt_a_int || gnt_b_int) begin
         state_d = gnt_a_int ? OWN_A : OWN_B;
         last_d  = gnt_a_int ? PORT_A : PORT_B;
         if (state_q == state_d) begin
            burst_d = (burst_q < MAX_CNT) ? burst_q + CNT_W'(1) : burst_q;
         end else begin
            burst_d = CNT_W'(1);
         end
      end
   end

   // Response registers: read data/valid or error one cycle after the grant
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         err_a_q    <= 1'b0;
         err_b_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         rvalid_a_q <= gnt_a_int & ~sel_we & in_range;
         rvalid_b_q <= gnt_b_int & ~sel_we & in_range;
         err_a_q    <= gnt_a_int & ~in_range;
         err_b_q    <= gnt_b_int & ~in_range;
         rdata_q    <= (gnt_any && !sel_we && in_range) ? mem_rdata : '0;
      end
   end

   // Outputs: memory strobes only in the grant cycle, responses zero when not valid
   always_comb begin
      gnt_a       = gnt_a_int;
      gnt_b       = gnt_b_int;
      mem_addr    = gnt_any ? sel_addr  : '0;
      mem_wdata   = gnt_any ? sel_wdata : '0;
      mem_write   = gnt_any &  sel_we & in_range;
      mem_read    = gnt_any & ~sel_we & in_range;
      rvalid_a    = rvalid_a_q & ~reset;
      rvalid_b    = rvalid_b_q & ~reset;
      err_a       = err_a_q & ~reset;
      err_b       = err_b_q & ~reset;
      rdata_a     = rvalid_a ? rdata_q : '0;
      rdata_b     = rvalid_b ? rdata_q : '0;
      dbg_state_o = state_q;
   end

endmodule
